symm_iter4: RTL and testbench
=============================

# symm_iter4

Symmetric-orthogonalisation update stage for the 4-component FastICA datapath. Sits directly downstream of the W·Wᵀ Gram stage. It takes the unmixing matrix W and its Gram matrix G = W·Wᵀ and computes one step of W ← 1.5·W − 0.5·(G·W) with a single time-shared multiply-accumulate. It presents the new W plus a max-abs-change figure to the iteration controller, which uses that figure for its convergence check.

## Interface
- DW, 26, signed data width of every matrix element
- FRAC, 13, fractional bits (Q12.13 fixed point)

- clk_iter  in  1  clock; all state updates on the rising edge
- rst_iter  in  1  synchronous, active-high reset
- en_iter  in  1  start request; accepted only in IDLE
- i11..i44  in  16×DW signed  W, row-major (iRC = row R, column C)
- g11..g44  in  16×DW signed  G = W·Wᵀ, row-major
- o11..o44  out  16×DW signed reg  updated W
- delta_iter  out  DW unsigned reg  max over elements of |o_new − i|, saturated
- busy_iter  out  1  high while computing
- done_iter  out  1 reg  one-cycle pulse when outputs are valid

## Operation
- States: IDLE, MAC, DONE.
- IDLE, en_iter=1:
  - latch all 32 inputs into internal W/G registers;
  - clear the accumulator, element index e=0, k=0 and running delta;
  - go to MAC.
- en_iter is ignored in MAC and DONE. The latched copies isolate the block from input changes after acceptance.
- MAC, one product per cycle:
  - acc += G[i][k]·W[k][j], where i=e/4, j=e%4.
  - Order: e = 0..15 (row-major), k = 0..3 inner.
- On k=3, finalise element e:
  - P = (acc + final product) >>> FRAC (arithmetic, floor).
  - x = 3·W[i][j] − P.
  - y = x >>> 1 (floor).
  - Saturate y to [−2^25, 2^25−1] and write it to internal result buffer[e].
  - d = |y_sat − W[i][j]|, saturated to 2^25−1; running delta = max(running delta, d).
  - Clear acc, k=0, e++.
- After e=15 finalises: copy the result buffer to o11..o44 and running delta to delta_iter, go to DONE.
- DONE: done_iter=1 for exactly one cycle, then IDLE.
- Outputs hold their last values from one DONE until the next; they never change mid-computation.
- busy_iter = (state==MAC), combinational from state.
- Width rules:
  - each product 2·DW=52 bits signed;
  - accumulator 54 bits signed (4-term sum, no overflow);
  - x computed at ≥43 bits signed before the shift;
  - saturation applied only to the final y.
- Reset, at any time including mid-MAC:
  - state=IDLE;
  - o11..o44=0, delta_iter=0, done_iter=0, busy_iter=0;
  - accumulator, indices and buffer cleared;
  - any in-flight computation is abandoned with no done pulse.

## Timing
- Start accepted at edge T0 (en_iter high in IDLE). Inputs are latched at T0, and busy_iter is high from just after T0.
- MAC occupies edges T0+1 … T0+64. Element e is finalised at edge T0+4e+4.
- Outputs and delta_iter update at edge T0+64. done_iter is high from T0+64 to T0+65; busy_iter is low during this cycle.
- Back in IDLE after T0+65. The earliest next start is sampled at T0+66, so the minimum start-to-start spacing is 66 cycles.
- en_iter held high continuously restarts at every IDLE, once per 66 cycles.
- Throughput: one matrix update per 66 cycles. The multiplier is a single 26×26 signed unit.

## Test plan
- Reset: assert rst_iter 2 cycles → o11..o44=0, delta_iter=0, busy_iter=0, done_iter=0. en_iter held while in reset → no start.
- Identity fixed point: W=I (diag 8192), G=I → done_iter exactly 64 edges after the start edge; outputs diag 8192, off-diag 0; delta_iter=0.
- Scaled: W=2I (16384), G=4I (32768) → P diag 65536, so output diag −8192, off-diag 0; delta_iter=24576.
- Saturation and rounding, two runs:
  - W diag 33554431, G=0 → output diag 33554431 (saturated), delta_iter=0;
  - W11=−1, all else 0, G=0 → o11=−2, delta_iter=1.
- Protocol:
  - pulse en_iter at cycles 10 and 40 of one run → only one done_iter; outputs reflect the first operands, even though i/g change after acceptance.
  - rst_iter at cycle 30 of a run → outputs 0, no done_iter; a following start completes normally.
- Full random: 200 random W/G pairs in ±2^24 → every output and delta_iter match a bit-exact reference model (floor shifts, saturation) at done_iter.

Source files
------------

// File: rtl/symm_iter4.sv
// symm_iter4: one symmetric-orthogonalisation step W <- 1.5W - 0.5GW using a single time-shared MAC
module symm_iter4 #(
    parameter int DW   = 26,
    parameter int FRAC = 13
) (
    input  logic                 clk_iter,
    input  logic                 rst_iter,
    input  logic                 en_iter,
    input  logic signed [DW-1:0] i11, i12, i13, i14, i21, i22, i23, i24,
    input  logic signed [DW-1:0] i31, i32, i33, i34, i41, i42, i43, i44,
    input  logic signed [DW-1:0] g11, g12, g13, g14, g21, g22, g23, g24,
    input  logic signed [DW-1:0] g31, g32, g33, g34, g41, g42, g43, g44,
    output logic signed [DW-1:0] o11, o12, o13, o14, o21, o22, o23, o24,
    output logic signed [DW-1:0] o31, o32, o33, o34, o41, o42, o43, o44,
    output logic        [DW-1:0] delta_iter,
    output logic                 busy_iter,
    output logic                 done_iter
);
    localparam int AW = 2 * DW + 2;
    localparam logic signed [AW-1:0] SMAX = (AW'(1) <<< (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SMIN = -(AW'(1) <<< (DW - 1));

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                r_state;
    logic signed [DW-1:0]  r_w [16];
    logic signed [DW-1:0]  r_g [16];
    logic signed [DW-1:0]  r_buf [16];
    logic signed [DW-1:0]  r_o [16];
    logic signed [AW-1:0]  r_acc;
    logic        [3:0]     r_e;
    logic        [1:0]     r_k;
    logic        [DW-1:0]  r_delta;
    logic        [DW-1:0]  r_dout;
    logic                  r_done;

    logic signed [DW-1:0]   w_win [16];
    logic signed [DW-1:0]   w_gin [16];
    logic signed [DW-1:0]   w_a, w_b, w_wij, w_ysat;
    logic signed [2*DW-1:0] w_ax, w_bx, w_prod;
    logic signed [AW-1:0]   w_sum, w_p, w_wx, w_x, w_y;
    logic signed [DW:0]     w_diff;
    logic        [DW:0]     w_abs;
    logic        [DW-1:0]   w_d, w_max;

    assign w_win = '{i11, i12, i13, i14, i21, i22, i23, i24, i31, i32, i33, i34, i41, i42, i43, i44};
    assign w_gin = '{g11, g12, g13, g14, g21, g22, g23, g24, g31, g32, g33, g34, g41, g42, g43, g44};

    assign w_a    = r_g[{r_e[3:2], r_k}];
    assign w_b    = r_w[{r_k, r_e[1:0]}];
    assign w_wij  = r_w[r_e];
    assign w_ax   = {{DW{w_a[DW-1]}}, w_a};
    assign w_bx   = {{DW{w_b[DW-1]}}, w_b};
    assign w_prod = w_ax * w_bx;
    assign w_sum  = r_acc + {{2{w_prod[2*DW-1]}}, w_prod};
    assign w_p    = w_sum >>> FRAC;
    assign w_wx   = {{(AW-DW){w_wij[DW-1]}}, w_wij};
    assign w_x    = AW'(3) * w_wx - w_p;
    assign w_y    = w_x >>> 1;
    assign w_ysat = (w_y > SMAX) ? SMAX[DW-1:0] : (w_y < SMIN) ? SMIN[DW-1:0] : w_y[DW-1:0];
    assign w_diff = {w_ysat[DW-1], w_ysat} - {w_wij[DW-1], w_wij};
    assign w_abs  = w_diff[DW] ? -w_diff : w_diff;
    // |diff| can reach 2^26-1, so clamp anything at or above 2^25
    assign w_d    = (w_abs[DW] | w_abs[DW-1]) ? {1'b0, {(DW-1){1'b1}}} : w_abs[DW-1:0];
    assign w_max  = (w_d > r_delta) ? w_d : r_delta;

    always_ff @(posedge clk_iter) begin
        if (rst_iter) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_e     <= '0;
            r_k     <= '0;
            r_delta <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            for (int n = 0; n < 16; n++) begin
                r_w[n]   <= '0;
                r_g[n]   <= '0;
                r_buf[n] <= '0;
                r_o[n]   <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (en_iter) begin
                        r_w     <= w_win;
                        r_g     <= w_gin;
                        r_acc   <= '0;
                        r_e     <= '0;
                        r_k     <= '0;
                        r_delta <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    if (r_k == 2'd3) begin
                        r_buf[r_e] <= w_ysat;
                        r_delta    <= w_max;
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_e        <= r_e + 4'd1;
                        if (r_e == 4'd15) begin
                            // element 15 is still being written, so bypass it into the output copy
                            for (int n = 0; n < 16; n++)
                                r_o[n] <= (n == 15) ? w_ysat : r_buf[n];
                            r_dout  <= w_max;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + 2'd1;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_iter  = (r_state == MAC);
    assign done_iter  = r_done;
    assign delta_iter = r_dout;
    assign o11 = r_o[0];
    assign o12 = r_o[1];
    assign o13 = r_o[2];
    assign o14 = r_o[3];
    assign o21 = r_o[4];
    assign o22 = r_o[5];
    assign o23 = r_o[6];
    assign o24 = r_o[7];
    assign o31 = r_o[8];
    assign o32 = r_o[9];
    assign o33 = r_o[10];
    assign o34 = r_o[11];
    assign o41 = r_o[12];
    assign o42 = r_o[13];
    assign o43 = r_o[14];
    assign o44 = r_o[15];
endmodule

// File: tb/tb_symm_iter4.sv
// tb_symm_iter4: randomized and directed checks of symm_iter4 against a cycle-level behavioural model
module tb_symm_iter4;
    localparam longint SMAX = 33554431;
    localparam longint SMIN = -33554432;

    logic clk_iter = 1'b0;
    logic rst_iter = 1'b1;
    logic en_iter  = 1'b0;
    logic signed [25:0] ti [16];
    logic signed [25:0] tg [16];
    logic signed [25:0] to [16];
    logic [25:0] delta_iter;
    logic busy_iter, done_iter;

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    int ph = 0, cnt = 0, ed = 0, pendd = 0;
    int eo [16];
    int pend [16];
    bit edone = 0;

    int wm [16];
    int gm [16];

    always #5 clk_iter = ~clk_iter;

    symm_iter4 dut (
        .clk_iter(clk_iter), .rst_iter(rst_iter), .en_iter(en_iter),
        .i11(ti[0]), .i12(ti[1]), .i13(ti[2]), .i14(ti[3]),
        .i21(ti[4]), .i22(ti[5]), .i23(ti[6]), .i24(ti[7]),
        .i31(ti[8]), .i32(ti[9]), .i33(ti[10]), .i34(ti[11]),
        .i41(ti[12]), .i42(ti[13]), .i43(ti[14]), .i44(ti[15]),
        .g11(tg[0]), .g12(tg[1]), .g13(tg[2]), .g14(tg[3]),
        .g21(tg[4]), .g22(tg[5]), .g23(tg[6]), .g24(tg[7]),
        .g31(tg[8]), .g32(tg[9]), .g33(tg[10]), .g34(tg[11]),
        .g41(tg[12]), .g42(tg[13]), .g43(tg[14]), .g44(tg[15]),
        .o11(to[0]), .o12(to[1]), .o13(to[2]), .o14(to[3]),
        .o21(to[4]), .o22(to[5]), .o23(to[6]), .o24(to[7]),
        .o31(to[8]), .o32(to[9]), .o33(to[10]), .o34(to[11]),
        .o41(to[12]), .o42(to[13]), .o43(to[14]), .o44(to[15]),
        .delta_iter(delta_iter), .busy_iter(busy_iter), .done_iter(done_iter)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // W_new = floor((3W - floor(GW / 2^13)) / 2), clamped to 26 bits
    function automatic void calc(input int w [16], input int g [16], output int ro [16], output int rd);
        longint s, x, y, d;
        rd = 0;
        for (int e = 0; e < 16; e++) begin
            s = 0;
            for (int k = 0; k < 4; k++)
                s += longint'(g[(e / 4) * 4 + k]) * longint'(w[k * 4 + e % 4]);
            x = 3 * longint'(w[e]) - (s >>> 13);
            y = x >>> 1;
            if (y > SMAX) y = SMAX;
            if (y < SMIN) y = SMIN;
            d = y - longint'(w[e]);
            if (d < 0) d = -d;
            if (d > SMAX) d = SMAX;
            ro[e] = int'(y);
            if (int'(d) > rd) rd = int'(d);
        end
    endfunction

    always @(posedge clk_iter) begin
        int w [16];
        int g [16];
        if (rst_iter) begin
            ph = 0; cnt = 0; ed = 0; edone = 0;
            for (int n = 0; n < 16; n++) eo[n] = 0;
        end else if (ph == 0) begin
            edone = 0;
            if (en_iter) begin
                for (int n = 0; n < 16; n++) begin
                    w[n] = int'(ti[n]);
                    g[n] = int'(tg[n]);
                end
                calc(w, g, pend, pendd);
                ph = 1; cnt = 0;
            end
        end else if (ph == 1) begin
            cnt++;
            if (cnt == 64) begin
                eo = pend; ed = pendd; edone = 1; ph = 2;
            end
        end else begin
            edone = 0; ph = 0;
        end
    end

    always @(negedge clk_iter) begin
        int bi;
        if (chk_on) begin
            chk("busy", longint'(busy_iter), longint'(ph == 1));
            chk("done", longint'(done_iter), longint'(edone));
            chk("delta", longint'(delta_iter), longint'(ed));
            bi = -1;
            for (int n = 0; n < 16; n++)
                if (bi < 0 && int'(to[n]) != eo[n]) bi = n;
            chk($sformatf("out[%0d]", bi < 0 ? 0 : bi), longint'(to[bi < 0 ? 0 : bi]), longint'(eo[bi < 0 ? 0 : bi]));
        end
    end

    task automatic load();
        for (int n = 0; n < 16; n++) begin
            ti[n] = wm[n][25:0];
            tg[n] = gm[n][25:0];
        end
    endtask

    task automatic clear_mats();
        for (int n = 0; n < 16; n++) begin
            wm[n] = 0;
            gm[n] = 0;
        end
    endtask

    task automatic rand_mats();
        for (int n = 0; n < 16; n++) begin
            wm[n] = int'($urandom_range(33554432, 0)) - 16777216;
            gm[n] = int'($urandom_range(33554432, 0)) - 16777216;
        end
    endtask

    task automatic start_only();
        repeat (2) @(negedge clk_iter);
        en_iter = 1'b1;
        @(posedge clk_iter);
        #1 en_iter = 1'b0;
    endtask

    task automatic wait_done(input int tgt);
        int lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk_iter);
            #1;
            if (done_iter) begin
                lat = n;
                break;
            end
        end
        chk("latency", lat, tgt);
    endtask

    task automatic count_dones(input int cycles, output int c);
        c = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk_iter);
            #1;
            if (done_iter) c++;
        end
    endtask

    initial begin
        int c;
        clear_mats();
        load();
        en_iter = 1'b1;
        @(posedge clk_iter);
        chk_on = 1;
        @(posedge clk_iter);
        #1;
        chk("rst_o11", longint'(to[0]), 0);
        chk("rst_delta", longint'(delta_iter), 0);
        chk("rst_busy", longint'(busy_iter), 0);
        chk("rst_done", longint'(done_iter), 0);
        rst_iter = 1'b0;
        en_iter = 1'b0;

        clear_mats();
        for (int n = 0; n < 4; n++) begin wm[n * 5] = 8192; gm[n * 5] = 8192; end
        load();
        start_only();
        wait_done(64);
        chk("ident_o11", longint'(to[0]), 8192);
        chk("ident_o44", longint'(to[15]), 8192);
        chk("ident_o12", longint'(to[1]), 0);
        chk("ident_delta", longint'(delta_iter), 0);

        clear_mats();
        for (int n = 0; n < 4; n++) begin wm[n * 5] = 16384; gm[n * 5] = 32768; end
        load();
        start_only();
        wait_done(64);
        chk("scaled_o22", longint'(to[5]), -8192);
        chk("scaled_o23", longint'(to[6]), 0);
        chk("scaled_delta", longint'(delta_iter), 24576);

        clear_mats();
        for (int n = 0; n < 4; n++) wm[n * 5] = 33554431;
        load();
        start_only();
        wait_done(64);
        chk("sat_o33", longint'(to[10]), 33554431);
        chk("sat_delta", longint'(delta_iter), 0);

        clear_mats();
        wm[0] = -1;
        load();
        start_only();
        wait_done(64);
        chk("neg_o11", longint'(to[0]), -2);
        chk("neg_delta", longint'(delta_iter), 1);

        clear_mats();
        for (int n = 0; n < 4; n++) begin wm[n * 5] = 8192; gm[n * 5] = 8192; end
        load();
        start_only();
        rand_mats();
        load();
        repeat (29) @(posedge clk_iter);
        #1 en_iter = 1'b1;
        @(posedge clk_iter);
        #1 en_iter = 1'b0;
        count_dones(100, c);
        chk("proto_dones", c, 1);
        chk("proto_o11", longint'(to[0]), 8192);
        chk("proto_o21", longint'(to[4]), 0);

        clear_mats();
        for (int n = 0; n < 4; n++) begin wm[n * 5] = 8192; gm[n * 5] = 8192; end
        load();
        start_only();
        repeat (29) @(posedge clk_iter);
        #1 rst_iter = 1'b1;
        @(posedge clk_iter);
        #1 rst_iter = 1'b0;
        chk("midrst_o11", longint'(to[0]), 0);
        chk("midrst_busy", longint'(busy_iter), 0);
        count_dones(80, c);
        chk("midrst_dones", c, 0);
        start_only();
        wait_done(64);
        chk("after_rst_o11", longint'(to[0]), 8192);

        for (int r = 0; r < 200; r++) begin
            rand_mats();
            load();
            start_only();
            rand_mats();
            load();
            wait_done(64);
        end

        rand_mats();
        load();
        repeat (2) @(posedge clk_iter);
        #1 en_iter = 1'b1;
        count_dones(200, c);
        en_iter = 1'b0;
        chk("cont_dones", c, 3);
        repeat (80) @(posedge clk_iter);
        @(negedge clk_iter);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
